gcn_mem_responder: RTL
======================

Name: gcn_mem_responder

Overview:
- Responder end of the GCN read interfaces: holds the feature/weight (FM/WM) rows and the COO adjacency columns.
- Answers the accelerator's `read_address`/`enable_read` and `coo_address` requests with `data_in` and `coo_in`.
- Filled beforehand by a host write stream. Issues `start` to the accelerator once loading completes, then returns to idle when the accelerator raises `done`.

Parameters:
- WEIGHT_ROWS, 96, elements per FM/WM row word
- WEIGHT_WIDTH, 5, bits per element
- ADDRESS_WIDTH, 13, FM/WM read address width
- MEM_DEPTH, 16, FM/WM words stored; must be ≤ 2**ADDRESS_WIDTH
- COO_NUM_OF_COLS, 6, COO columns stored
- COO_BW, $clog2(COO_NUM_OF_COLS), COO index/element width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- load_valid  in  1  host write request
- load_ready  out  1  responder accepts write this cycle
- load_sel  in  1  0 = FM/WM word, 1 = COO column
- load_addr  in  ADDRESS_WIDTH  target word/column index
- load_data  in  WEIGHT_ROWS x WEIGHT_WIDTH  FM/WM word; for COO, elements [0] and [1] (low COO_BW bits) are rows 0 and 1
- load_last  in  1  final host write; ends LOAD
- start  out  1  one-cycle pulse to accelerator
- enable_read  in  1  FM/WM read request
- read_address  in  ADDRESS_WIDTH  FM/WM word address
- data_in  out  WEIGHT_ROWS x WEIGHT_WIDTH  FM/WM read data
- coo_address  in  COO_BW  COO column index
- coo_in  out  2 x COO_BW  COO column (row 0, row 1)
- done  in  1  accelerator completion
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: all outputs 0. `data_in` and `coo_in` are all zero. Memory contents are not reset.
- Asserting reset mid-operation returns to IDLE immediately. Memory contents survive.
- FSM states and transitions:
  - IDLE: `load_ready`=1. An accepted write (`load_valid` && `load_ready`) moves to LOAD and stores that word.
  - LOAD: `load_ready`=1. Every accepted write stores one word. An accepted write with `load_last`=1 stores the word and moves to STARTUP. An accepted write with `load_last` in IDLE also moves straight to STARTUP.
  - STARTUP: one cycle. `start`=1, `load_ready`=0. Next state is SERVE.
  - SERVE: `load_ready`=0; host writes are ignored. A `done` rising edge (`done`=1, previous `done`=0) moves to IDLE.
- Store rules:
  - FM/WM write lands at mem[`load_addr`].
  - COO write lands at coo[`load_addr`].
  - Writes with `load_addr` ≥ MEM_DEPTH (FM/WM) or ≥ COO_NUM_OF_COLS (COO) are dropped.
- FM/WM read path, latency 1 cycle:
  - If `enable_read`=1 at edge N, `data_in` after edge N = mem[`read_address`] (registered).
  - If `read_address` ≥ MEM_DEPTH, `data_in` is all zeros.
  - If `enable_read`=0, `data_in` holds its last value.
  - Reads are honoured in every state.
- COO read path, latency 1 cycle:
  - `coo_in` is registered from coo[`coo_address`] every cycle, unconditionally.
  - An out-of-range index returns zeros.
- Same-cycle write and read to the same address in LOAD: the read returns the old data (read-before-write).
- `start` is never asserted outside STARTUP.
- `done` held high across IDLE→LOAD→SERVE does not re-trigger, because only rising edges count.

Optional Feature:
- Macro: GCN_MEM_ERR_EN.
- When defined, adds output `err` (1 bit, reset 0). `err` is sticky and is set on any of:
  - a dropped out-of-range write;
  - an FM/WM read with `read_address` ≥ MEM_DEPTH and `enable_read`=1;
  - a COO read of an out-of-range index while in SERVE.
- `err` clears only on reset.
- When undefined: no `err` port, no extra logic; all other behaviour is identical.

Decomposition:
- Package `gcn_mem_pkg`:
  - FSM state enum {IDLE, LOAD, STARTUP, SERVE};
  - row-word typedef (WEIGHT_ROWS x WEIGHT_WIDTH);
  - COO column typedef (2 x COO_BW);
  - LOAD_SEL_FMWM / LOAD_SEL_COO constants.
- One sub-module, `gcn_sync_ram`: single write port, single registered read port, read-before-write, out-of-range reads return zero. Instantiated twice: FM/WM words and COO columns.

Test Plan:
- Reset defaults: apply reset → all outputs 0, `load_ready`=1 after release, state IDLE.
- Load-then-read: write mem[0..5] with element0 = addr+1, then `load_last` → `start` pulses exactly once, one cycle after the last write. Then `enable_read` with `read_address`=3 → `data_in[0]`=4 on the next cycle.
- COO: load coo[2] = (1,4); drive `coo_address`=2 in SERVE → `coo_in` = (1,4) one cycle later. Index 7 (COO_NUM_OF_COLS=6) → (0,0).
- Read-before-write: in LOAD, write mem[1]=0x1F while reading address 1 → returns the previous value; the next read returns 0x1F.
- Done/reset: in SERVE, host writes are ignored and `load_ready`=0. A `done` pulse → IDLE, `busy`=0. Assert reset mid-LOAD → IDLE, `start` never pulses.
- GCN_MEM_ERR_EN: read `read_address`=20 with `enable_read`=1 → `err`=1, stays 1 until reset, and `data_in` = 0.

Source files
------------

// File: rtl/gcn_mem_pkg.sv
// Shared types and constants for the GCN memory responder.
// Default sizes here match the responder's parameter defaults.
package gcn_mem_pkg;

    localparam int GCN_WEIGHT_ROWS     = 96;
    localparam int GCN_WEIGHT_WIDTH    = 5;
    localparam int GCN_ADDRESS_WIDTH   = 13;
    localparam int GCN_MEM_DEPTH       = 16;
    localparam int GCN_COO_NUM_OF_COLS = 6;
    localparam int GCN_COO_BW          = $clog2(GCN_COO_NUM_OF_COLS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        STARTUP = 2'd2,
        SERVE   = 2'd3
    } gcn_state_t;

    typedef logic [GCN_WEIGHT_ROWS-1:0][GCN_WEIGHT_WIDTH-1:0] row_word_t;

    // Element [0] is COO row 0, element [1] is COO row 1.
    typedef logic [1:0][GCN_COO_BW-1:0] coo_col_t;

    localparam logic LOAD_SEL_FMWM = 1'b0;
    localparam logic LOAD_SEL_COO  = 1'b1;

endpackage

// File: rtl/gcn_sync_ram.sv
// Synchronous RAM: one write port, one registered read port (read-before-write).
// Out-of-range reads return zero; out-of-range writes are discarded.
module gcn_sync_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int              IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIMIT = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic              w_ok;
    logic              r_ok;

    assign w_ok = ({1'b0, waddr} < LIMIT);
    assign r_ok = ({1'b0, raddr} < LIMIT);

    // NOTE: the array has no reset so it maps onto plain RAM; contents survive a reset.
    always_ff @(posedge clk) begin
        if (we && w_ok) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    // NOTE: non-blocking updates mean a read on the same edge as a write sees the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_ok ? mem[raddr[IDX_W-1:0]] : '0;
        end
    end

endmodule

// File: rtl/gcn_mem_responder.sv
// Responder side of the GCN read interfaces: host-loaded FM/WM and COO stores.
// Define GCN_MEM_ERR_EN to add a sticky err output flagging out-of-range accesses.
module gcn_mem_responder
    import gcn_mem_pkg::*;
#(
    parameter int WEIGHT_ROWS     = GCN_WEIGHT_ROWS,
    parameter int WEIGHT_WIDTH    = GCN_WEIGHT_WIDTH,
    parameter int ADDRESS_WIDTH   = GCN_ADDRESS_WIDTH,
    parameter int MEM_DEPTH       = GCN_MEM_DEPTH,
    parameter int COO_NUM_OF_COLS = GCN_COO_NUM_OF_COLS,
    parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     load_valid,
    output logic                                     load_ready,
    input  logic                                     load_sel,
    input  logic [ADDRESS_WIDTH-1:0]                 load_addr,
    input  logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] load_data,
    input  logic                                     load_last,
    output logic                                     start,
    input  logic                                     enable_read,
    input  logic [ADDRESS_WIDTH-1:0]                 read_address,
    output logic [WEIGHT_ROWS-1:0][WEIGHT_WIDTH-1:0] data_in,
    input  logic [COO_BW-1:0]                        coo_address,
    output logic [1:0][COO_BW-1:0]                   coo_in,
    input  logic                                     done,
    output logic                                     busy
`ifdef GCN_MEM_ERR_EN
    ,
    output logic                                     err
`endif
);

    localparam logic [ADDRESS_WIDTH:0] FM_LIMIT     = MEM_DEPTH[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] COO_WR_LIMIT = COO_NUM_OF_COLS[ADDRESS_WIDTH:0];

    gcn_state_t             state;
    gcn_state_t             state_next;
    logic                   done_q;
    logic                   done_rise;
    logic                   accept;
    logic                   fm_wr_ok;
    logic                   coo_wr_ok;
    logic                   fm_we;
    logic                   coo_we;
    logic [1:0][COO_BW-1:0] coo_wdata;

    assign accept    = load_valid && load_ready;
    assign done_rise = done && !done_q;
    assign fm_wr_ok  = ({1'b0, load_addr} < FM_LIMIT);
    assign coo_wr_ok = ({1'b0, load_addr} < COO_WR_LIMIT);
    assign fm_we     = accept && (load_sel == LOAD_SEL_FMWM) && fm_wr_ok;
    // The full-width range check matters: the COO RAM only sees the low index bits.
    assign coo_we    = accept && (load_sel == LOAD_SEL_COO) && coo_wr_ok;

    assign coo_wdata[0] = load_data[0][COO_BW-1:0];
    assign coo_wdata[1] = load_data[1][COO_BW-1:0];

    // NOTE: assigning state_next before the case keeps every path covered, so no latch forms.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = load_last ? STARTUP : LOAD;
                end
            end
            LOAD: begin
                if (accept && load_last) begin
                    state_next = STARTUP;
                end
            end
            STARTUP: state_next = SERVE;
            SERVE: begin
                if (done_rise) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from state_next so they hold 0 throughout reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            load_ready <= 1'b0;
            start      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            done_q     <= done;
            load_ready <= (state_next == IDLE) || (state_next == LOAD);
            start      <= (state_next == STARTUP);
            busy       <= (state_next != IDLE);
        end
    end

    gcn_sync_ram #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDRESS_WIDTH),
        .DATA_W (WEIGHT_ROWS * WEIGHT_WIDTH)
    ) u_fm_ram (
        .clk   (clk),
        .reset (reset),
        .we    (fm_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (enable_read),
        .raddr (read_address),
        .rdata (data_in)
    );

    gcn_sync_ram #(
        .DEPTH  (COO_NUM_OF_COLS),
        .ADDR_W (COO_BW),
        .DATA_W (2 * COO_BW)
    ) u_coo_ram (
        .clk   (clk),
        .reset (reset),
        .we    (coo_we),
        .waddr (load_addr[COO_BW-1:0]),
        .wdata (coo_wdata),
        .re    (1'b1),
        .raddr (coo_address),
        .rdata (coo_in)
    );

`ifdef GCN_MEM_ERR_EN
    localparam logic [ADDRESS_WIDTH:0] FM_RD_LIMIT  = MEM_DEPTH[ADDRESS_WIDTH:0];
    localparam logic [COO_BW:0]        COO_RD_LIMIT = COO_NUM_OF_COLS[COO_BW:0];

    logic wr_ok;
    logic err_event;

    assign wr_ok = (load_sel == LOAD_SEL_FMWM) ? fm_wr_ok : coo_wr_ok;

    always_comb begin
        err_event = 1'b0;
        if (accept && !wr_ok) begin
            err_event = 1'b1;
        end
        if (enable_read && !({1'b0, read_address} < FM_RD_LIMIT)) begin
            err_event = 1'b1;
        end
        if ((state == SERVE) && !({1'b0, coo_address} < COO_RD_LIMIT)) begin
            err_event = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (err_event) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
